bcd_count_ctrl: RTL and testbench

//  Run/pause/stop controller for a cascaded NDIG-digit BCD up/down counter.

---
 rtl/bcd_count_ctrl.sv | 158 +++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - run/pause/stop controller for a cascaded NDIG-digit BCD up/down counter
module bcd_count_ctrl #(
    parameter int NDIG = 2,
    parameter int DIV  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              load,
    input  logic              dir,
    input  logic              auto_reload,
    input  logic [4*NDIG-1:0] load_val,
    input  logic [4*NDIG-1:0] limit,
    output logic [4*NDIG-1:0] digits,
    output logic [1:0]        state,
    output logic              busy,
    output logic              tc
);

    localparam int W  = 4 * NDIG;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t         state_q;
    logic [W-1:0]   digits_q;
    logic [W-1:0]   preset_q;
    logic [PW-1:0]  presc_q;
    logic           dir_q;
    logic           reload_q;
    logic           busy_q;
    logic           tc_q;

    logic [W-1:0]   load_clamp;
    logic [W-1:0]   limit_clamp;
    logic [W-1:0]   terminal;
    logic [W-1:0]   inc_val;
    logic [W-1:0]   dec_val;
    logic           carry;
    logic           borrow;
    logic           tick;
    logic           at_term;

    // Force every nibble into the 0..9 range so stored digits stay valid BCD
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign load_clamp  = clamp_bcd(load_val);
    assign limit_clamp = clamp_bcd(limit);
    assign terminal    = dir_q ? limit_clamp : '0;
    assign at_term     = (digits_q == terminal);
    assign tick        = (state_q == S_RUN) && (presc_q == PLAST);

    // Ripple BCD +1 / -1 across the digit chain; full-width wrap falls out naturally
    always_comb begin
        carry   = 1'b1;
        borrow  = 1'b1;
        inc_val = digits_q;
        dec_val = digits_q;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digits_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Control FSM: command priority stop > load > start > pause, ticks stepped only in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            preset_q <= '0;
            presc_q  <= '0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                presc_q <= '0;
            end else if (state_q == S_RUN) begin
                // load and start have no effect while running
                if (pause) begin
                    state_q <= S_PAUSE;
                    busy_q  <= 1'b1;
                end else if (tick) begin
                    presc_q <= '0;
                    if (at_term) begin
                        tc_q <= 1'b1;
                        if (reload_q) begin
                            digits_q <= preset_q;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        digits_q <= dir_q ? inc_val : dec_val;
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end else if (load) begin
                preset_q <= load_clamp;
                digits_q <= load_clamp;
            end else if (start) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                // resuming from PAUSE keeps prescale phase and direction
                if (state_q != S_PAUSE) begin
                    dir_q    <= dir;
                    reload_q <= auto_reload;
                    presc_q  <= '0;
                    if (state_q == S_DONE) begin
                        digits_q <= preset_q;
                    end
                end
            end
        end
    end

    assign digits = digits_q;
    assign state  = state_q;
    assign busy   = busy_q;
    assign tc     = tc_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - self-checking bench for bcd_count_ctrl with an integer-valued reference model
module tb_bcd_count_ctrl;

    localparam int NDIG = 2;
    localparam int DIV  = 4;
    localparam int W    = 4 * NDIG;
    localparam int MOD  = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop = 1'b0;
    logic         load = 1'b0;
    logic         dir = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] digits;
    logic [1:0]   state;
    logic         busy;
    logic         tc;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // reference model: the count as a plain integer, the prescale phase as elapsed RUN cycles
    int m_val, m_preset, m_state, m_elapsed;
    bit m_up, m_ar, m_tc;

    bcd_count_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .load(load), .dir(dir), .auto_reload(auto_reload), .load_val(load_val),
        .limit(limit), .digits(digits), .state(state), .busy(busy), .tc(tc)
    );

    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r;
        int d;
        r = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] b;
        int t;
        t = v;
        b = '0;
        for (int i = 0; i < NDIG; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_preset = 0; m_state = 0; m_elapsed = 0;
        m_up = 1'b0; m_ar = 1'b0; m_tc = 1'b0;
    endtask

    task automatic model_step();
        int term;
        m_tc = 1'b0;
        if (stop) begin
            m_state = 0;
            m_elapsed = 0;
        end else if (m_state == 1) begin
            if (pause) begin
                m_state = 2;
            end else begin
                m_elapsed++;
                if (m_elapsed == DIV) begin
                    m_elapsed = 0;
                    term = m_up ? bcd_to_int(limit) : 0;
                    if (m_val == term) begin
                        m_tc = 1'b1;
                        if (m_ar) m_val = m_preset;
                        else m_state = 3;
                    end else begin
                        m_val = m_up ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
                    end
                end
            end
        end else if (load) begin
            m_preset = bcd_to_int(load_val);
            m_val = m_preset;
        end else if (start) begin
            if (m_state != 2) begin
                m_up = dir;
                m_ar = auto_reload;
                m_elapsed = 0;
                if (m_state == 3) m_val = m_preset;
            end
            m_state = 1;
        end
    endtask

    // compare process: every output against the model, mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            chk("digits", 32'(digits), 32'(int_to_bcd(m_val)));
            chk("state", 32'(state), 32'(m_state));
            chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
            chk("tc", 32'(tc), 32'(m_tc));
        end
    end

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic ar, input logic [W-1:0] lim);
        start = 1'b1; dir = d; auto_reload = ar; limit = lim;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_tc", 32'(tc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        #2;
        check_en = 1'b1;
        chk("por_digits", 32'(digits), 32'h0);
        chk("por_state", 32'(state), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // 1: asynchronous reset mid-run
        do_load(8'h45);
        do_start(1'b1, 1'b0, 8'h99);
        cyc(6);
        chk("t1_running", 32'(digits), 32'h46);
        cyc(1);
        async_reset();

        // 2: up count 07 -> 12 then DONE
        do_load(8'h07);
        do_start(1'b1, 1'b0, 8'h12);
        cyc(4);
        chk("t2_first_step", 32'(digits), 32'h08);
        cyc(16);
        chk("t2_at_limit", 32'(digits), 32'h12);
        cyc(3);
        chk("t2_no_tc_yet", 32'(tc), 32'h0);
        cyc(1);
        chk("t2_tc", 32'(tc), 32'h1);
        chk("t2_done", 32'(state), 32'h3);
        chk("t2_hold", 32'(digits), 32'h12);
        cyc(1);
        chk("t2_tc_one_cycle", 32'(tc), 32'h0);

        // 3: down count with auto reload
        do_stop();
        do_load(8'h03);
        do_start(1'b0, 1'b1, 8'h00);
        cyc(12);
        chk("t3_zero", 32'(digits), 32'h00);
        cyc(4);
        chk("t3_tc", 32'(tc), 32'h1);
        chk("t3_reload", 32'(digits), 32'h03);
        chk("t3_still_run", 32'(state), 32'h1);
        cyc(16);
        chk("t3_tc_again", 32'(tc), 32'h1);

        // 4: carry across both digits and full wrap
        do_stop();
        do_load(8'h98);
        do_start(1'b1, 1'b0, 8'h01);
        cyc(8);
        chk("t4_wrap", 32'(digits), 32'h00);
        cyc(4);
        chk("t4_limit", 32'(digits), 32'h01);
        cyc(4);
        chk("t4_tc", 32'(tc), 32'h1);

        // 5: pause preserves prescale phase
        do_stop();
        do_load(8'h00);
        do_start(1'b1, 1'b0, 8'h99);
        cyc(10);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        cyc(10);
        chk("t5_paused_digits", 32'(digits), 32'h02);
        chk("t5_paused_state", 32'(state), 32'h2);
        do_start(1'b0, 1'b0, 8'h99);
        cyc(1);
        chk("t5_not_yet", 32'(digits), 32'h02);
        cyc(1);
        chk("t5_resume_step", 32'(digits), 32'h03);

        // 6: simultaneous commands
        stop = 1'b1; start = 1'b1;
        cyc(1);
        stop = 1'b0; start = 1'b0;
        chk("t6_stop_wins", 32'(state), 32'h0);
        do_start(1'b1, 1'b0, 8'h99);
        do_load(8'h55);
        chk("t6_load_in_run", 32'(digits), 32'h03);
        do_stop();
        do_load(8'h05);
        do_start(1'b1, 1'b0, 8'h05);
        cyc(3);
        do_stop();
        chk("t6_stop_on_tc_state", 32'(state), 32'h0);
        chk("t6_stop_on_tc_tc", 32'(tc), 32'h0);
        do_load(8'hAF);
        chk("t6_clamp", 32'(digits), 32'h99);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            stop        = ($urandom_range(0, 99) < 2);
            load        = ($urandom_range(0, 99) < 5);
            start       = ($urandom_range(0, 99) < 10);
            pause       = ($urandom_range(0, 99) < 5);
            dir         = 1'($urandom_range(0, 1));
            auto_reload = 1'($urandom_range(0, 1));
            load_val    = W'($urandom);
            if ($urandom_range(0, 7) == 0) limit = W'($urandom);
            if (i == 2000) async_reset();
            cyc(1);
        end
        stop = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        cyc(2);
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
